mem_access_unit: RTL and testbench

//   MEM-stage data-memory access unit of the 5-stage RV32I pipeline. Takes the EX_MEM outputs (address, store data,

---
 rtl/mem_access_unit_pkg.sv | 27 ++
 rtl/mem_access_unit_if.sv | 23 ++
 rtl/mem_access_unit_align.sv | 49 ++++
 rtl/mem_access_unit.sv | 136 +++++++++++++
 tb/tb_mem_access_unit.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the MEM-stage access unit: RV32I load/store funct3
// codes, FSM state encodings and the timeout counter width.
package mem_access_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int unsigned CNT_W = 16;

    function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
        if (is_store)
            return (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
        return (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
               (funct3 == F3_LBU) || (funct3 == F3_LHU);
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/ready bus between the MEM-stage access unit (master)
// and data memory (slave).
interface mem_access_unit_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_rdata, dmem_ready
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_rdata, dmem_ready
    );

endinterface

// File: rtl/mem_access_unit_align.sv
// Combinational lane steering: store data/strobes, load extraction with sign
// or zero extension, and natural-alignment check.
module load_store_align
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] load_data_o,
    output logic        misalign_o
);

    logic [31:0] rshift;

    always_comb begin
        wdata_o = store_data_i;
        wstrb_o = 4'b1111;
        case (funct3_i)
            F3_SB: begin
                wdata_o = {4{store_data_i[7:0]}};
                wstrb_o = 4'b0001 << addr_lo_i;
            end
            F3_SH: begin
                wdata_o = {2{store_data_i[15:0]}};
                wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    assign rshift = rdata_i >> {addr_lo_i, 3'b000};

    always_comb begin
        case (funct3_i)
            F3_LB:   load_data_o = {{24{rshift[7]}}, rshift[7:0]};
            F3_LH:   load_data_o = {{16{rshift[15]}}, rshift[15:0]};
            F3_LBU:  load_data_o = {24'd0, rshift[7:0]};
            F3_LHU:  load_data_o = {16'd0, rshift[15:0]};
            default: load_data_o = rdata_i;
        endcase
    end

    assign misalign_o = ((funct3_i[1:0] == 2'b01) && addr_lo_i[0]) ||
                        ((funct3_i[1:0] == 2'b10) && (addr_lo_i != 2'b00));

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: IDLE/WAIT/DONE request FSM with timeout,
// registered request fields and aligned load result for MEM_WB.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_read_mem,
    input  logic               mem_write_mem,
    input  logic               bubble_mem,
    input  logic [2:0]         funct3_mem,
    input  logic [31:0]        alu_result_mem,
    input  logic [31:0]        rs2_data_mem,
    mem_access_unit_if.master  dmem,
    output logic [31:0]        mem2reg_data,
    output logic               stall_req,
    output logic               access_fault
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic [31:0]      m2r_q, m2r_d;
    logic             fault_q, fault_d;

    logic             access, legal, timeout_hit;
    logic [31:0]      lsa_wdata, lsa_load;
    logic [3:0]       lsa_wstrb;
    logic             lsa_misalign;

    load_store_align u_align (
        .funct3_i     (funct3_mem),
        .addr_lo_i    (alu_result_mem[1:0]),
        .store_data_i (rs2_data_mem),
        .rdata_i      (dmem.dmem_rdata),
        .wdata_o      (lsa_wdata),
        .wstrb_o      (lsa_wstrb),
        .load_data_o  (lsa_load),
        .misalign_o   (lsa_misalign)
    );

    assign access      = (mem_read_mem | mem_write_mem) & ~bubble_mem;
    assign legal       = ~(mem_read_mem & mem_write_mem) &
                         funct3_legal(mem_write_mem, funct3_mem) & ~lsa_misalign;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign stall_req   = (state_q == ST_WAIT) | ((state_q == ST_IDLE) & access & legal);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        m2r_d   = m2r_q;
        fault_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (access && legal) begin
                    req_d   = 1'b1;
                    we_d    = mem_write_mem;
                    addr_d  = {alu_result_mem[31:2], 2'b00};
                    wdata_d = lsa_wdata;
                    wstrb_d = mem_write_mem ? lsa_wstrb : '0;
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end else if (access) begin
                    fault_d = 1'b1;
                    m2r_d   = '0;
                end
            end
            ST_WAIT: begin
                // Ready takes priority over a timeout landing on the same cycle.
                if (dmem.dmem_ready) begin
                    if (!we_q)
                        m2r_d = lsa_load;
                    req_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    req_d   = 1'b0;
                    m2r_d   = '0;
                    fault_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            m2r_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            m2r_q   <= m2r_d;
            fault_q <= fault_d;
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_wstrb = wstrb_q;
    assign mem2reg_data    = m2r_q;
    assign access_fault    = fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed corner cases plus random
// loads/stores against a byte-level memory and access-rule reference model.
module tb_mem_access_unit;

    localparam int unsigned TB_TIMEOUT = 4;
    localparam logic [31:0] BASE = 32'h100;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_mem, mem_write_mem, bubble_mem;
    logic [2:0]  funct3_mem;
    logic [31:0] alu_result_mem, rs2_data_mem, mem2reg_data;
    logic        stall_req, access_fault;

    mem_access_unit_if dmem_bus();

    mem_access_unit #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read_mem   (mem_read_mem),
        .mem_write_mem  (mem_write_mem),
        .bubble_mem     (bubble_mem),
        .funct3_mem     (funct3_mem),
        .alu_result_mem (alu_result_mem),
        .rs2_data_mem   (rs2_data_mem),
        .dmem           (dmem_bus),
        .mem2reg_data   (mem2reg_data),
        .stall_req      (stall_req),
        .access_fault   (access_fault)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] mem [64];
    logic [31:0] exp_m2r;
    logic        exp_fault;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int unsigned ref_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit ref_legal(input bit rd, input bit wr, input logic [2:0] f3,
                                     input logic [31:0] addr);
        if (rd && wr) return 1'b0;
        if (rd && !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1'b0;
        if (wr && !(f3 inside {3'b000, 3'b001, 3'b010})) return 1'b0;
        return (addr % ref_size(f3)) == 0;
    endfunction

    function automatic logic [3:0] ref_wstrb(input logic [2:0] f3, input logic [31:0] addr);
        int unsigned m;
        m = ((1 << ref_size(f3)) - 1) << (addr % 4);
        return 4'(m);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        if (ref_size(f3) == 1) return (rs2 & 32'hFF) * 32'h01010101;
        if (ref_size(f3) == 2) return (rs2 & 32'hFFFF) * 32'h00010001;
        return rs2;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
        longint v;
        v = longint'(word >> (8 * (addr % 4)));
        case (f3)
            3'b000: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
            3'b001: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
            3'b100: v = v % 256;
            3'b101: v = v % 65536;
            default: v = longint'(word);
        endcase
        return 32'(v);
    endfunction

    // Presents one instruction in MEM starting just after a rising edge and
    // plays data memory, answering `delay` WAIT cycles after the first.
    task automatic do_instr(input bit rd, input bit wr, input bit bub, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] rs2,
                            input int unsigned delay);
        bit          access, legal, completed, timed_out;
        int unsigned waits, stalls, exp_waits, idx;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_wstrb;
        mem_read_mem   = rd;
        mem_write_mem  = wr;
        bubble_mem     = bub;
        funct3_mem     = f3;
        alu_result_mem = addr;
        rs2_data_mem   = rs2;
        access  = (rd || wr) && !bub;
        legal   = ref_legal(rd, wr, f3, addr);
        e_addr  = addr - (addr % 4);
        idx     = (e_addr - BASE) / 4;
        e_wstrb = wr ? ref_wstrb(f3, addr) : 4'b0000;
        e_wdata = ref_wdata(f3, rs2);
        stalls  = 0;

        @(negedge clk);
        check_eq("idle_stall", 32'(stall_req), 32'(access && legal));
        check_eq("idle_req", 32'(dmem_bus.dmem_req), 32'd0);
        check_eq("fault_pulse", 32'(access_fault), 32'(exp_fault));
        check_eq("m2r_hold", mem2reg_data, exp_m2r);
        if (stall_req) stalls++;
        @(posedge clk); #1;
        exp_fault = 1'b0;

        if (access && !legal) begin
            exp_fault = 1'b1;
            exp_m2r   = '0;
        end else if (access) begin
            completed = 1'b0;
            timed_out = 1'b0;
            waits     = 0;
            while (!completed && !timed_out) begin
                @(negedge clk);
                if (stall_req) stalls++;
                check_eq("wait_req", 32'(dmem_bus.dmem_req), 32'd1);
                check_eq("wait_addr", dmem_bus.dmem_addr, e_addr);
                check_eq("wait_we", 32'(dmem_bus.dmem_we), 32'(wr));
                check_eq("wait_wstrb", 32'(dmem_bus.dmem_wstrb), 32'(e_wstrb));
                if (wr) check_eq("wait_wdata", dmem_bus.dmem_wdata, e_wdata);
                if (waits == delay) begin
                    dmem_bus.dmem_ready = 1'b1;
                    dmem_bus.dmem_rdata = wr ? $urandom : mem[idx];
                end
                @(posedge clk); #1;
                dmem_bus.dmem_ready = 1'b0;
                dmem_bus.dmem_rdata = $urandom;
                if (waits == delay)                completed = 1'b1;
                else if (waits + 1 == TB_TIMEOUT)  timed_out = 1'b1;
                waits++;
            end
            if (completed && rd) exp_m2r = ref_load(f3, addr, mem[idx]);
            if (completed && wr)
                for (int b = 0; b < 4; b++)
                    if (e_wstrb[b]) mem[idx][8*b +: 8] = e_wdata[8*b +: 8];
            if (timed_out) begin
                exp_m2r   = '0;
                exp_fault = 1'b1;
            end
            exp_waits = (delay < TB_TIMEOUT) ? delay + 1 : TB_TIMEOUT;
            @(negedge clk);
            check_eq("done_stall", 32'(stall_req), 32'd0);
            check_eq("done_req", 32'(dmem_bus.dmem_req), 32'd0);
            check_eq("done_fault", 32'(access_fault), 32'(exp_fault));
            check_eq("done_m2r", mem2reg_data, exp_m2r);
            check_eq("stall_cycles", stalls, 1 + exp_waits);
            @(posedge clk); #1;
            exp_fault = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned t0, r, delay;
        bit          rd, wr, bub;
        logic [2:0]  f3;
        logic [31:0] addr;

        rst = 1'b1;
        mem_read_mem = 1'b0; mem_write_mem = 1'b0; bubble_mem = 1'b0;
        funct3_mem = '0; alu_result_mem = '0; rs2_data_mem = '0;
        dmem_bus.dmem_ready = 1'b0;
        dmem_bus.dmem_rdata = '0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        exp_m2r = '0;
        exp_fault = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req", 32'(dmem_bus.dmem_req), 32'd0);
        check_eq("rst_we", 32'(dmem_bus.dmem_we), 32'd0);
        check_eq("rst_wstrb", 32'(dmem_bus.dmem_wstrb), 32'd0);
        check_eq("rst_addr", dmem_bus.dmem_addr, 32'd0);
        check_eq("rst_wdata", dmem_bus.dmem_wdata, 32'd0);
        check_eq("rst_m2r", mem2reg_data, 32'd0);
        check_eq("rst_fault", 32'(access_fault), 32'd0);
        check_eq("rst_stall", 32'(stall_req), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        mem[0] = 32'hDEADBEEF;
        do_instr(1, 0, 0, 3'b010, 32'h100, 32'h0, 1);
        check_eq("lw_result", mem2reg_data, 32'hDEADBEEF);
        mem[0] = 32'h80112233;
        do_instr(1, 0, 0, 3'b000, 32'h103, 32'h0, 0);
        check_eq("lb_result", mem2reg_data, 32'hFFFFFF80);
        do_instr(1, 0, 0, 3'b100, 32'h103, 32'h0, 2);
        check_eq("lbu_result", mem2reg_data, 32'h00000080);
        do_instr(1, 0, 0, 3'b101, 32'h102, 32'h0, 0);
        check_eq("lhu_result", mem2reg_data, 32'h00008011);
        do_instr(0, 1, 0, 3'b000, 32'h101, 32'h000000AB, 0);
        do_instr(0, 1, 0, 3'b001, 32'h102, 32'h00001234, 1);
        do_instr(1, 0, 0, 3'b010, 32'h102, 32'h0, 0);
        do_instr(1, 1, 0, 3'b010, 32'h100, 32'h0, 0);
        do_instr(0, 0, 0, 3'b000, 32'h100, 32'h0, 0);
        do_instr(1, 0, 1, 3'b010, 32'h104, 32'h0, 0);
        do_instr(1, 0, 0, 3'b010, 32'h104, 32'h0, 50);
        do_instr(0, 1, 0, 3'b010, 32'h108, 32'h12345678, 50);
        do_instr(1, 0, 0, 3'b010, 32'h108, 32'h0, TB_TIMEOUT - 1);

        t0 = cyc;
        do_instr(1, 0, 0, 3'b010, 32'h10C, 32'h0, 0);
        do_instr(0, 1, 0, 3'b010, 32'h110, 32'hCAFEF00D, 0);
        check_eq("b2b_cycles", cyc - t0, 32'd6);

        mem_read_mem = 1'b1; mem_write_mem = 1'b0; bubble_mem = 1'b0;
        funct3_mem = 3'b010; alu_result_mem = 32'h100;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("rstw_req_before", 32'(dmem_bus.dmem_req), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        mem_read_mem = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rstw_req", 32'(dmem_bus.dmem_req), 32'd0);
        check_eq("rstw_stall", 32'(stall_req), 32'd0);
        check_eq("rstw_m2r", mem2reg_data, 32'd0);
        dmem_bus.dmem_ready = 1'b1;
        dmem_bus.dmem_rdata = 32'h5A5A5A5A;
        @(posedge clk); #1;
        dmem_bus.dmem_ready = 1'b0;
        @(negedge clk);
        check_eq("stale_ready_req", 32'(dmem_bus.dmem_req), 32'd0);
        check_eq("stale_ready_m2r", mem2reg_data, 32'd0);
        check_eq("stale_ready_fault", 32'(access_fault), 32'd0);
        @(posedge clk); #1;
        exp_m2r = '0;
        exp_fault = 1'b0;

        for (int n = 0; n < 200; n++) begin
            r   = $urandom_range(0, 99);
            rd  = (r < 45) || (r >= 95);
            wr  = (r >= 45 && r < 90) || (r >= 95);
            bub = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0)
                f3 = 3'($urandom);
            else if (wr)
                f3 = 3'($urandom_range(0, 2));
            else begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 == 3'b011) f3 = 3'b101;
            end
            addr = BASE + $urandom_range(0, 255);
            if ($urandom_range(0, 2) != 0) addr = addr & ~32'h3;
            delay = $urandom_range(0, 5);
            do_instr(rd, wr, bub, f3, addr, $urandom, delay);
        end
        do_instr(0, 0, 0, 3'b000, 32'h100, 32'h0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
